// File: rtl/seq_player_if.sv
// Bundle between the game FSM and the playback stage: request side plus
// the registered LED/status side.
interface seq_player_if #(
  parameter int STEPS = 16
);
  logic                 start;
  logic                 stop;
  logic [3:0]           round;
  logic [STEPS*4-1:0]   seq;
  logic [3:0]           led;
  logic [3:0]           step_idx;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stop, round, seq,
    input  led, step_idx, busy, done
  );

  modport slave (
    input  start, stop, round, seq,
    output led, step_idx, busy, done
  );
endinterface

// File: rtl/seq_player.sv
// Plays steps 0..round of a latched one-hot colour sequence on the LEDs,
// each shown for ON_CYCLES then dark for OFF_CYCLES, then pulses done.
module seq_player #(
  parameter int STEPS      = 16,
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         R,
  seq_player_if.slave  bus
);
  localparam int SW   = STEPS * 4;
  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   shadow_reg, shadow_next;
  logic [3:0]      round_reg, round_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [3:0]      led_reg, led_next;
  logic [3:0]      idx_reg, idx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            last_step;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      round_reg  <= '0;
      timer_reg  <= '0;
      led_reg    <= '0;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      round_reg  <= round_next;
      timer_reg  <= timer_next;
      led_reg    <= led_next;
      idx_reg    <= idx_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Also stop at the physical end of the sequence so step_idx cannot wrap.
  assign last_step = (idx_reg == round_reg) || (idx_reg == LAST_IDX);

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    round_next  = round_reg;
    timer_next  = timer_reg;
    led_next    = led_reg;
    idx_next    = idx_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_next  = SHOW;
          shadow_next = bus.seq;
          round_next  = bus.round;
          idx_next    = '0;
          led_next    = bus.seq[3:0];
          busy_next   = 1'b1;
          timer_next  = ON_LOAD;
        end
      end
      SHOW: begin
        if (bus.stop) begin
          state_next = IDLE;
          led_next   = '0;
          idx_next   = '0;
          busy_next  = 1'b0;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          state_next = GAP;
          led_next   = '0;
          timer_next = OFF_LOAD;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      GAP: begin
        if (bus.stop) begin
          state_next = IDLE;
          led_next   = '0;
          idx_next   = '0;
          busy_next  = 1'b0;
          timer_next = '0;
        end else if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else if (!last_step) begin
          state_next  = SHOW;
          idx_next    = idx_reg + 4'd1;
          shadow_next = {4'b0000, shadow_reg[SW-1:4]};
          led_next    = shadow_reg[7:4];
          timer_next  = ON_LOAD;
        end else begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        led_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.led      = led_reg;
  assign bus.step_idx = idx_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
endmodule
